// File: rtl/altr_hps_interface_register_bank.sv
// Multi-stage interface register bank with valid, stall and flush.
// In test mode every flop, valid bits included, forms one serial scan chain.
module altr_hps_interface_register_bank #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test_ctrl,
  input  logic             scanen,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             scan_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             scan_out
);

  localparam int SW = WIDTH + 1;
  localparam int N  = DEPTH * SW;

  // Stage s occupies chain[s*SW +: SW]: valid in the low bit, data above it.
  logic [N-1:0] chain;
  logic [N-1:0] chain_next;
  logic [N-1:0] rst_vec;
  logic [N-1:0] vld_mask;
  logic [N-1:0] adv_vec;
  logic         shift;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    assign rst_vec[s*SW]              = 1'b0;
    assign rst_vec[s*SW+1 +: WIDTH]   = RESET_VAL;
    assign vld_mask[s*SW]             = 1'b1;
    assign vld_mask[s*SW+1 +: WIDTH]  = {WIDTH{1'b0}};
    if (s == 0) begin : g_first
      assign adv_vec[0 +: SW] = {data_in, valid_in};
    end else begin : g_rest
      assign adv_vec[s*SW +: SW] = chain[(s-1)*SW +: SW];
    end
  end

  assign shift = scanen | test_ctrl;

  always_comb begin
    chain_next = chain;
    if (shift) begin
      chain_next = {chain[N-2:0], scan_in};
    end else if (flush) begin
      chain_next = chain & ~vld_mask;
    end else if (en) begin
      chain_next = adv_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= rst_vec;
    end else begin
      chain <= chain_next;
    end
  end

  assign data_out  = chain[(DEPTH-1)*SW+1 +: WIDTH];
  assign valid_out = chain[(DEPTH-1)*SW];
  assign scan_out  = chain[N-1];

endmodule

// File: tb/tb_altr_hps_interface_register_bank.sv
// Self-checking bench for altr_hps_interface_register_bank (WIDTH=8, DEPTH=2, RESET_VAL=8'hA5).
// A stage-level reference model feeds an output scoreboard; scan tests use a delayed-bit scoreboard.
module tb_altr_hps_interface_register_bank;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = D * (W + 1);
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         test_ctrl = 1'b0;
  logic         scanen = 1'b0;
  logic         en = 1'b0;
  logic         flush = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         scan_in = 1'b0;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         scan_out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [W-1:0] data;
    logic         valid;
    logic         scan;
  } exp_t;

  exp_t         exp_q[$];
  logic         bit_q[$];
  logic [W-1:0] md[D];
  logic         mv[D];

  altr_hps_interface_register_bank #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .test_ctrl(test_ctrl), .scanen(scanen), .en(en),
    .flush(flush), .valid_in(valid_in), .data_in(data_in), .scan_in(scan_in),
    .data_out(data_out), .valid_out(valid_out), .scan_out(scan_out)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_pack();
    logic [N-1:0] c;
    c = '0;
    for (int s = 0; s < D; s++) begin
      c[s*(W+1)] = mv[s];
      for (int b = 0; b < W; b++) c[s*(W+1)+1+b] = md[s][b];
    end
    return c;
  endfunction

  task automatic model_unpack(input logic [N-1:0] c);
    for (int s = 0; s < D; s++) begin
      mv[s] = c[s*(W+1)];
      for (int b = 0; b < W; b++) md[s][b] = c[s*(W+1)+1+b];
    end
  endtask

  // Drive one cycle, advance the model, push the expected outputs, clock, then pop and compare.
  task automatic step(input logic r, input logic tc, input logic se, input logic e,
                      input logic f, input logic vi, input logic [W-1:0] di, input logic si);
    logic [N-1:0] c;
    exp_t ex;
    exp_t got;
    rst = r; test_ctrl = tc; scanen = se; en = e; flush = f;
    valid_in = vi; data_in = di; scan_in = si;
    if (r) begin
      for (int s = 0; s < D; s++) begin md[s] = RV; mv[s] = 1'b0; end
    end else if (tc | se) begin
      c = model_pack();
      c = {c[N-2:0], si};
      model_unpack(c);
    end else if (f) begin
      for (int s = 0; s < D; s++) mv[s] = 1'b0;
    end else if (e) begin
      for (int s = D-1; s > 0; s--) begin md[s] = md[s-1]; mv[s] = mv[s-1]; end
      md[0] = di; mv[0] = vi;
    end
    c = model_pack();
    ex.data = md[D-1]; ex.valid = mv[D-1]; ex.scan = c[N-1];
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    n_tests++;
    if ({data_out, valid_out, scan_out} !== {got.data, got.valid, got.scan}) begin
      n_fail++;
      $display("FAIL model_outputs: data/valid/scan got %h/%b/%b expected %h/%b/%b",
               data_out, valid_out, scan_out, got.data, got.valid, got.scan);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({data_out, valid_out, scan_out} !== {8'hA5, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: data/valid/scan got %h/%b/%b expected a5/0/1", data_out, valid_out, scan_out);
    end
  endtask

  task automatic test_latency();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL latency_edge1: valid_out got %b expected 0", valid_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    n_tests++;
    if ({data_out, valid_out} !== {8'h3C, 1'b1}) begin
      n_fail++; $display("FAIL latency_edge2: data/valid got %h/%b expected 3c/1", data_out, valid_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL latency_edge3: valid_out got %b expected 0", valid_out);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
      n_tests++;
      if ({data_out, valid_out} !== {8'h11, 1'b1}) begin
        n_fail++; $display("FAIL stall_hold: cycle %0d data/valid got %h/%b expected 11/1", i, data_out, valid_out);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    n_tests++;
    if ({data_out, valid_out} !== {8'h22, 1'b1}) begin
      n_fail++; $display("FAIL stall_resume: data/valid got %h/%b expected 22/1", data_out, valid_out);
    end
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hBB, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
    n_tests++;
    if ({data_out, valid_out} !== {8'hAA, 1'b0}) begin
      n_fail++; $display("FAIL flush_edge: data/valid got %h/%b expected aa/0", data_out, valid_out);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      n_tests++;
      if (valid_out !== 1'b0) begin
        n_fail++; $display("FAIL flush_after: cycle %0d valid_out got %b expected 0", i, valid_out);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5E, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h6F, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    n_tests++;
    if ({data_out, valid_out} !== {8'h5E, 1'b0}) begin
      n_fail++; $display("FAIL flush_stalled: data/valid got %h/%b expected 5e/0", data_out, valid_out);
    end
  endtask

  task automatic test_scan(input logic use_tc);
    logic [N-1:0] pat;
    logic         si;
    logic         want;
    pat = 18'h2B4C9;
    do_reset();
    bit_q.delete();
    for (int i = 0; i < 2*N; i++) begin
      si = (i < N) ? pat[i] : 1'b0;
      bit_q.push_back(si);
      step(1'b0, use_tc, ~use_tc, 1'b1, 1'b1, 1'b1, 8'hFF, si);
      if (i >= N-1) begin
        want = bit_q.pop_front();
        n_tests++;
        if (scan_out !== want) begin
          n_fail++; $display("FAIL scan_stream: tc=%b edge %0d scan_out got %b expected %b", use_tc, i+1, scan_out, want);
        end
      end
    end
    do_reset();
    for (int i = 0; i < N; i++) step(1'b0, use_tc, ~use_tc, 1'b0, 1'b0, 1'b0, 8'h00, pat[i]);
    n_tests++;
    if ({data_out, valid_out} !== {8'h93, 1'b0}) begin
      n_fail++; $display("FAIL scan_loaded: tc=%b data/valid got %h/%b expected 93/0", use_tc, data_out, valid_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    n_tests++;
    if ({data_out, valid_out} !== {8'h5A, 1'b1}) begin
      n_fail++; $display("FAIL scan_to_func: tc=%b data/valid got %h/%b expected 5a/1", use_tc, data_out, valid_out);
    end
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    n_tests++;
    if ({data_out, valid_out, scan_out} !== {8'hA5, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_shift: data/valid/scan got %h/%b/%b expected a5/0/1", data_out, valid_out, scan_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
           $urandom_range(0, 1), ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
           8'($urandom), $urandom_range(0, 1));
    end
  endtask

  initial begin
    for (int s = 0; s < D; s++) begin md[s] = RV; mv[s] = 1'b0; end
    @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_scan(1'b0);
    test_scan(1'b1);
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
